// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed big-endian byte
// stream and writes 32-bit words at byte addresses 0, 4, 8, ... while holding the core.
module imem_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [31:0]       wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [15:0]       word_count,
   output logic [2:0]        dbg_state
);

   // Handshake: a byte is consumed on a rising edge where byte_valid && byte_ready;
   // byte_ready depends only on state, so the source may hold byte_valid as long as it likes.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t            state, state_nxt;
   logic [15:0]       len;
   logic [1:0]        byte_cnt;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       word;
   logic              accept;
   logic [15:0]       len_in;
   logic              last_word;

   assign accept    = byte_valid && byte_ready;
   assign len_in    = {len[15:8], byte_in};
   assign last_word = ({{(16-ADDR_W){1'b0}}, idx} + 16'd1) == len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN_HI;
         S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
         S_LEN_LO: begin
            if (accept) begin
               if ({1'b0, len_in} > DEPTH_L) state_nxt = S_ERR;
               else if (len_in == 16'd0)     state_nxt = S_DONE;
               else                          state_nxt = S_DATA;
            end
         end
         S_DATA:  if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
         S_WRITE: state_nxt = last_word ? S_DONE : S_DATA;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len        <= '0;
         byte_cnt   <= '0;
         idx        <= '0;
         word       <= '0;
         word_count <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  len        <= '0;
                  byte_cnt   <= '0;
                  idx        <= '0;
                  word_count <= '0;
               end
            end
            S_LEN_HI: if (accept) len[15:8] <= byte_in;
            S_LEN_LO: begin
               if (accept) begin
                  len[7:0] <= byte_in;
                  byte_cnt <= '0;
               end
            end
            S_DATA: begin
               if (accept) begin
                  word     <= {word[23:0], byte_in};
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
            S_WRITE: begin
               idx        <= idx + 1'b1;
               word_count <= word_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
   assign wr_en      = (state == S_WRITE);
   assign wr_addr    = {{(30-ADDR_W){1'b0}}, idx, 2'b00};
   assign wr_data    = word;
   assign cpu_hold   = (state != S_DONE);
   assign done       = (state == S_DONE);
   assign err        = (state == S_ERR);
   assign dbg_state  = state;

endmodule
